// File: rtl/sync_mux_arb.sv
// Round-robin scheduler feeding a mux-based CDC synchronizer: latch winner word, hold en, then gap.
// Optional `SYNC_MUX_ARB_ACK_EN adds ack_i; the HOLD phase then also waits for the destination ack.
module sync_mux_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int HOLD       = 4,
  parameter int GAP        = 2
) (
  input  logic                        clk_0,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        en_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
`ifdef SYNC_MUX_ARB_ACK_EN
  ,
  input  logic                        ack_i
`endif
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0]      grant_q, grant_d;

  logic                  found;
  logic [IW-1:0]         win;
  logic [IW:0]           sum;
  logic                  hold_done;

`ifdef SYNC_MUX_ARB_ACK_EN
  assign hold_done = (cnt_q == '0) && ack_i;
`else
  assign hold_done = (cnt_q == '0);
`endif

  // Scan from last+1 upward with wrap; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && found) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    en_d    = en_q;
    data_d  = data_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (found) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          last_d  = win;
          en_d    = 1'b1;
          data_d  = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          grant_d = N_REQ'(1) << win;
        end
      end
      S_HOLD: begin
        if (hold_done) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
          en_d    = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      en_q    <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      en_q    <= en_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign en_o    = en_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sync_mux_arb.sv
// Bench for sync_mux_arb: transfer-age model checked every cycle plus directed literal checks.
module tb_sync_mux_arb;
  localparam int W = 32, N = 4, HOLD = 4, GAP = 2;

  logic           clk_0 = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic           ack_i = 1'b1;
  logic [N-1:0]   req_ready, grant_o;
  logic           en_o, busy_o;
  logic [W-1:0]   data_o;

  sync_mux_arb #(.DATA_WIDTH(W), .N_REQ(N), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk_0(clk_0), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .en_o(en_o), .data_o(data_o), .grant_o(grant_o),
    .busy_o(busy_o)
`ifdef SYNC_MUX_ARB_ACK_EN
    , .ack_i(ack_i)
`endif
  );

  always #5 clk_0 = ~clk_0;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transfer is just an age 1..HOLD+GAP since acceptance; 0 means idle.
  int           m_age = 0, m_owner = 0, m_last = N-1;
  logic [W-1:0] m_data = '0;
  logic         ack_eff;
`ifdef SYNC_MUX_ARB_ACK_EN
  assign ack_eff = ack_i;
`else
  assign ack_eff = 1'b1;
`endif

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(posedge clk_0 or negedge rst_n) begin
    if (!rst_n) begin
      m_age = 0; m_owner = 0; m_last = N-1; m_data = '0;
    end else if (m_age == 0) begin
      int w;
      w = pick(req_valid, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_data = req_data[w*W +: W]; m_age = 1;
      end
    end else if (m_age == HOLD && !ack_eff) begin
      m_age = HOLD;
    end else if (m_age == HOLD + GAP) begin
      m_age = 0;
    end else begin
      m_age = m_age + 1;
    end
  end

  always @(negedge clk_0) begin
    int w;
    logic [N-1:0] exp_rdy, exp_gnt;
    w = pick(req_valid, m_last);
    exp_rdy = (rst_n && m_age == 0 && w >= 0) ? N'(1) << w : '0;
    exp_gnt = (m_age != 0) ? N'(1) << m_owner : '0;
    chk("cmp_en", 64'(en_o), 64'(m_age >= 1 && m_age <= HOLD));
    chk("cmp_busy", 64'(busy_o), 64'(m_age != 0));
    chk("cmp_data", 64'(data_o), 64'(m_data));
    chk("cmp_grant", 64'(grant_o), 64'(exp_gnt));
    chk("cmp_ready", 64'(req_ready), 64'(exp_rdy));
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  en_seq;
    int          gidx[5], gcyc[5], n, en_cnt;

    // Reset values, then idle with no requests
    #12;
    chk("rst_en", 64'(en_o), 64'h0);
    chk("rst_data", 64'(data_o), 64'h0);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    step(); rst_n = 1'b1;
    repeat (3) step();
    chk("idle_en", 64'(en_o), 64'h0);
    chk("idle_busy", 64'(busy_o), 64'h0);

    // Single request from requester 2
    req_data[2*W +: W] = 32'hA5A5_0002;
    req_valid = 4'b0100;
    @(negedge clk_0);
    chk("single_ready", 64'(req_ready), 64'h4);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) req_valid = '0;
      @(negedge clk_0);
      en_seq[k-1] = en_o;
      if (k == 1) chk("single_data", 64'(data_o), 64'hA5A5_0002);
      if (k == 7) chk("single_busy_end", 64'(busy_o), 64'h0);
    end
    chk("single_en_seq", 64'(en_seq), 64'h0F);

    // All four continuously valid: rotation 0,1,2,3,0 every HOLD+GAP+1 cycles
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1000_0000 + 32'(i * 17);
    req_valid = 4'b1111;
    n = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk_0);
      if (req_ready != '0 && n < 5) begin
        for (int j = 0; j < N; j++) if (req_ready[j]) gidx[n] = j;
        gcyc[n] = c;
        n++;
      end
      step();
    end
    chk("rr_count", 64'(n), 64'd5);
    chk("rr_g0", 64'(gidx[0]), 64'd0);
    chk("rr_g1", 64'(gidx[1]), 64'd1);
    chk("rr_g2", 64'(gidx[2]), 64'd2);
    chk("rr_g3", 64'(gidx[3]), 64'd3);
    chk("rr_g4", 64'(gidx[4]), 64'd0);
    chk("rr_period", 64'(gcyc[4] - gcyc[3]), 64'd7);
    req_valid = '0;

    // Requester 1 drops valid and scrambles data mid-HOLD
    do_reset();
    req_data[1*W +: W] = 32'hD00D_0001;
    req_valid = 4'b0010;
    @(negedge clk_0);
    chk("drop_ready", 64'(req_ready), 64'h2);
    en_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) begin
        req_valid = '0;
        req_data[1*W +: W] = 32'hFFFF_FFFF;
      end
      @(negedge clk_0);
      if (en_o) begin
        en_cnt++;
        chk("drop_data", 64'(data_o), 64'hD00D_0001);
      end
    end
    chk("drop_en_cnt", 64'(en_cnt), 64'd4);

    // Reset mid-transfer; requester 0 must win first afterwards
    step();
    req_valid = 4'b1001;
    @(negedge clk_0);
    chk("mid_ready_pre", 64'(req_ready), 64'h8);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(en_o), 64'h0);
    chk("mid_rst_data", 64'(data_o), 64'h0);
    chk("mid_rst_grant", 64'(grant_o), 64'h0);
    chk("mid_rst_busy", 64'(busy_o), 64'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk_0);
    chk("mid_ready_post", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    repeat (8) step();

`ifdef SYNC_MUX_ARB_ACK_EN
    // HOLD stretched until ack, then normal GAP
    begin
      logic [11:0] en_ack;
      do_reset();
      ack_i = 1'b0;
      req_data[0 +: W] = 32'h0ACC_0000;
      req_valid = 4'b0001;
      @(negedge clk_0);
      chk("ack_ready", 64'(req_ready), 64'h1);
      for (int k = 1; k <= 12; k++) begin
        step();
        if (k == 1) req_valid = '0;
        if (k == 9) ack_i = 1'b1;
        if (k == 10) ack_i = 1'b0;
        @(negedge clk_0);
        en_ack[k-1] = en_o;
      end
      chk("ack_en_seq", 64'(en_ack), 64'h1FF);
      chk("ack_busy_end", 64'(busy_o), 64'h0);
      ack_i = 1'b1;
    end
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_mux_arb.md
# sync_mux_arb

Source-domain scheduler for the mux-based CDC synchronizer in the async FIFO path. Arbitrates round-robin among N_REQ requesters sharing one synchronizer channel, registers the winner's word onto the synchronizer's data input and drives its enable for a fixed hold window, then forces an enable-low gap before the next transfer. Runs entirely in the source clock domain, so the destination always sees stable data for the whole enable pulse.

## Interface
- DATA_WIDTH, 32, width of each requester word and of data_o
- N_REQ, 4, number of requesters (≥2)
- HOLD, 4, cycles en_o stays high per transfer (≥1)
- GAP, 2, cycles en_o stays low after each transfer (≥1)

Ports:
- clk_0  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request; must stay high with stable data until req_ready
- req_data  in  N_REQ*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  N_REQ  one-hot acceptance strobe, one cycle, combinational in IDLE
- en_o  out  1  to synchronizer en; registered
- data_o  out  DATA_WIDTH  to synchronizer data_i; registered
- grant_o  out  N_REQ  one-hot owner of current transfer; registered
- busy_o  out  1  high whenever state ≠ IDLE
- ack_i  in  1  only with SYNC_MUX_ARB_ACK_EN; destination acknowledge, already synchronized into clk_0 externally

## Operation
- FSM states: IDLE, HOLD, GAP. Reset state IDLE.
- IDLE: if any req_valid, pick winner by round-robin starting at index (last+1) mod N_REQ; assert req_ready[winner] this cycle; at the edge load data_o ← winner's word, en_o ← 1, grant_o ← onehot(winner), last ← winner, counter ← HOLD-1, go HOLD. No req_valid: stay IDLE, outputs unchanged except en_o=0.
- HOLD: en_o=1, data_o frozen. Counter decrements each cycle; at 0 → GAP, en_o ← 0, counter ← GAP-1.
- GAP: en_o=0, data_o still frozen, grant_o still owner. Counter at 0 → IDLE, grant_o ← 0.
- req_ready is never asserted outside IDLE; req_valid changes during HOLD/GAP are ignored.
- data_o keeps the last transferred word through IDLE (not cleared).
- Counter width $clog2(max(HOLD,GAP)+1); no wrap, reloaded on every state entry.
- Reset values: en_o=0, data_o=0, grant_o=0, busy_o=0, req_ready=0, last=N_REQ-1 (requester 0 wins first).
- rst_n low mid-transfer: all outputs go to reset values immediately (asynchronously), transfer dropped; requester keeps req_valid and is re-arbitrated after reset.

## Timing
- req_valid[i] high in IDLE cycle t → req_ready[i] high in t → en_o/data_o valid from t+1.
- en_o high cycles t+1 … t+HOLD; low t+HOLD+1 … t+HOLD+GAP; IDLE again at t+HOLD+GAP+1, earliest next req_ready there.
- Transfer period HOLD+GAP+1 cycles under continuous load; no starvation: each valid requester served within N_REQ transfers.
- data_o never changes while en_o=1 or during GAP.

## Configuration
- SYNC_MUX_ARB_ACK_EN defined: ack_i port present; HOLD exits only when counter=0 and ack_i=1 (stays HOLD otherwise, en_o held high, data stable); ack_i during GAP/IDLE ignored.
- Not defined: no ack_i port; HOLD exits purely on counter, behaviour as above.

## Test plan
- Reset: rst_n low → en_o=0, data_o=0, grant_o=0, busy_o=0; release with no requests → all stay 0.
- Single request: req_valid[2]=1, req_data word2=32'hA5A5_0002 at cycle t → req_ready=4'b0100 at t, en_o=1 t+1..t+4, data_o=32'hA5A5_0002, en_o=0 t+5..t+6, busy_o=0 at t+7.
- All four valid continuously → grants in order 0,1,2,3,0, one every 7 cycles; data_o matches granted word each time.
- Requester 1 drops req_valid mid-HOLD of requester 1's transfer → no effect; en_o still exactly 4 cycles, data stable.
- rst_n asserted at cycle t+2 of a transfer → en_o, data_o, grant_o =0 immediately; after release requester 0 wins first again.
- ACK_EN build: ack_i held 0 → en_o stays 1 past 4 cycles; ack_i=1 at cycle t+9 → GAP starts next cycle, en_o=0 for 2 cycles.
